// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S frame arbiter: FSM states, source ids,
// default word length and the saturating fill-frame counter helper.
package i2s_pkg;

  localparam int DEFAULT_WORD_LENGTH = 16;

  // ARB = output register empty, HOLD = output register full
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_HOLD = 2'd2
  } arb_state_e;

  localparam logic [1:0] SRC_S0   = 2'd0;
  localparam logic [1:0] SRC_S1   = 2'd1;
  localparam logic [1:0] SRC_FILL = 2'd2;

  localparam logic [15:0] UNDERRUN_MAX = 16'hFFFF;

  // Increment that sticks at the all-ones value
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == UNDERRUN_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/i2s_rr_arb2.sv
// Two-way round-robin selector. A lone request always wins; on a tie the
// requester that did not win last time is granted.
module i2s_rr_arb2 (
  input  logic [1:0] req_i,        // bit0 = source 0, bit1 = source 1
  input  logic       last_grant_i, // 0 = source 0 won last, 1 = source 1 won last
  output logic [1:0] grant_o
);

  // Grant is one-hot or zero
  always_comb begin
    grant_o    = 2'b00;
    grant_o[0] = req_i[0] & (~req_i[1] | last_grant_i);
    grant_o[1] = req_i[1] & (~req_i[0] | ~last_grant_i);
  end

endmodule

// File: rtl/i2s_frame_arbiter.sv
// Merges two stereo frame sources into one registered output toward an I2S
// master. Round-robin between the sources; if nothing arrives for
// FILL_TIMEOUT arbitration cycles a silent (all-zero) frame is inserted so
// the serializer never starves.
module i2s_frame_arbiter
  import i2s_pkg::*;
#(
  parameter int WORD_LENGTH  = DEFAULT_WORD_LENGTH,
  parameter int FILL_TIMEOUT = 28
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     count_clear,
  input  logic [2*WORD_LENGTH-1:0] s0_data,
  input  logic                     s0_valid,
  output logic                     s0_ready,
  input  logic [2*WORD_LENGTH-1:0] s1_data,
  input  logic                     s1_valid,
  output logic                     s1_ready,
  output logic [2*WORD_LENGTH-1:0] m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [1:0]               src_id,
  output logic                     underrun,
  output logic [15:0]              underrun_count
);

  localparam int FW = 2 * WORD_LENGTH;
  // One spare bit so FILL_TIMEOUT up to FW-2 always fits
  localparam int CW = $clog2(FW) + 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(FILL_TIMEOUT - 1);

  arb_state_e      state_q;
  logic [FW-1:0]   m_data_q;
  logic            m_valid_q;
  logic [1:0]      src_id_q;
  logic            underrun_q;
  logic [CW-1:0]   wait_q;
  logic            last_grant_q;
  logic [15:0]     underrun_count_q;
  logic [15:0]     underrun_count_d;

  logic [1:0]      grant;
  logic            arb_open;
  logic            fill_now;

  i2s_rr_arb2 u_rr (
    .req_i        ({s1_valid, s0_valid}),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  // Sources are only offered a slot while the output register is empty and
  // the block is enabled; reset blocks any handshake in the same cycle.
  always_comb begin
    arb_open = ~rst & enable & (state_q == ST_ARB);
    fill_now = arb_open & ~|grant & (wait_q == WAIT_LAST);
  end

  assign s0_ready = arb_open & grant[0];
  assign s1_ready = arb_open & grant[1];

  // Fill-frame counter: clear beats an increment in the same cycle
  always_comb begin
    underrun_count_d = underrun_count_q;
    if (count_clear)
      underrun_count_d = '0;
    else if (fill_now)
      underrun_count_d = sat_inc16(underrun_count_q);
  end

  // Fill-frame counter register
  always_ff @(posedge clk) begin
    if (rst) underrun_count_q <= '0;
    else     underrun_count_q <= underrun_count_d;
  end

  // Control FSM with registered output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      src_id_q     <= SRC_S0;
      underrun_q   <= 1'b0;
      wait_q       <= '0;
      last_grant_q <= 1'b1;   // s0 wins the first tie
    end else begin
      underrun_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          m_valid_q <= 1'b0;
          wait_q    <= '0;
          if (enable) state_q <= ST_ARB;
        end
        ST_ARB: begin
          if (!enable) begin
            // Drain: nothing held, so just drop back to idle
            state_q <= ST_IDLE;
            wait_q  <= '0;
          end else if (grant[0]) begin
            m_data_q     <= s0_data;
            m_valid_q    <= 1'b1;
            src_id_q     <= SRC_S0;
            last_grant_q <= 1'b0;
            wait_q       <= '0;
            state_q      <= ST_HOLD;
          end else if (grant[1]) begin
            m_data_q     <= s1_data;
            m_valid_q    <= 1'b1;
            src_id_q     <= SRC_S1;
            last_grant_q <= 1'b1;
            wait_q       <= '0;
            state_q      <= ST_HOLD;
          end else if (wait_q == WAIT_LAST) begin
            // Starved: emit silence; fairness history is left alone
            m_data_q   <= '0;
            m_valid_q  <= 1'b1;
            src_id_q   <= SRC_FILL;
            underrun_q <= 1'b1;
            wait_q     <= '0;
            state_q    <= ST_HOLD;
          end else begin
            wait_q <= wait_q + CW'(1);
          end
        end
        ST_HOLD: begin
          // A held frame is always delivered, even if enable has dropped
          if (m_ready) begin
            m_valid_q <= 1'b0;
            wait_q    <= '0;
            state_q   <= enable ? ST_ARB : ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign m_data         = m_data_q;
  assign m_valid        = m_valid_q;
  assign src_id         = src_id_q;
  assign underrun       = underrun_q;
  assign underrun_count = underrun_count_q;

endmodule

// File: tb/tb_i2s_frame_arbiter.sv
// Bench for i2s_frame_arbiter: directed scenarios with literal expectations
// plus a randomized run, all checked every cycle against a transaction-level
// model of the output register, fairness history and fill timer.
module tb_i2s_frame_arbiter;

  localparam int WL = 16;
  localparam int FT = 28;
  localparam int FW = 2 * WL;

  logic          clk = 1'b0;
  logic          rst, enable, count_clear;
  logic [FW-1:0] s0_data, s1_data;
  logic          s0_valid, s1_valid, s0_ready, s1_ready;
  logic [FW-1:0] m_data;
  logic          m_valid, m_ready;
  logic [1:0]    src_id;
  logic          underrun;
  logic [15:0]   underrun_count;

  always #5 clk = ~clk;

  i2s_frame_arbiter #(.WORD_LENGTH(WL), .FILL_TIMEOUT(FT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .count_clear(count_clear),
    .s0_data(s0_data), .s0_valid(s0_valid), .s0_ready(s0_ready),
    .s1_data(s1_data), .s1_valid(s1_valid), .s1_ready(s1_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .src_id(src_id), .underrun(underrun), .underrun_count(underrun_count)
  );

  int n_checks = 0;
  int n_errs   = 0;
  bit preload  = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Winner among the valid sources: -1 none, else 0/1
  function automatic int choose(bit v0, bit v1, int last);
    if (v0 && v1) return (last == 0) ? 1 : 0;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  // Reference model: "phase" 0 = asleep, 1 = slot empty, 2 = slot full.
  task automatic model_loop();
    int ph = 0, msrc = 0, mcnt = 0, mlast = 1, mwait = 0;
    bit mv = 0, mpulse = 0, on = 0;
    logic [FW-1:0] mdat = '0;
    int nph, nsrc, ncnt, nlast, nwait, pick;
    bit nmv, npulse, fillhit;
    logic [FW-1:0] ndat;
    forever begin
      @(negedge clk);
      if (preload) mcnt = 16'hFFFE;
      pick = choose(s0_valid, s1_valid, mlast);
      if (on) begin
        chk("m_valid", m_valid, mv);
        chk("m_data", m_data, mdat);
        chk("src_id", src_id, msrc);
        chk("underrun", underrun, mpulse);
        chk("underrun_count", underrun_count, mcnt);
        chk("s0_ready", s0_ready, !rst && ph == 1 && enable && pick == 0);
        chk("s1_ready", s1_ready, !rst && ph == 1 && enable && pick == 1);
      end
      nph = ph; nmv = mv; ndat = mdat; nsrc = msrc; nlast = mlast;
      nwait = mwait; npulse = 0; fillhit = 0; ncnt = mcnt;
      if (rst) begin
        nph = 0; nmv = 0; ndat = '0; nsrc = 0; ncnt = 0; nwait = 0; nlast = 1;
      end else begin
        if (ph == 0) begin
          nwait = 0;
          if (enable) nph = 1;
        end else if (ph == 1) begin
          if (!enable) begin
            nph = 0; nwait = 0;
          end else if (pick >= 0) begin
            ndat = (pick == 0) ? s0_data : s1_data;
            nmv = 1; nsrc = pick; nlast = pick; nph = 2; nwait = 0;
          end else if (mwait + 1 == FT) begin
            ndat = '0; nmv = 1; nsrc = 2; npulse = 1; fillhit = 1;
            nph = 2; nwait = 0;
          end else begin
            nwait = mwait + 1;
          end
        end else begin
          if (m_ready) begin
            nmv = 0; nwait = 0; nph = enable ? 1 : 0;
          end
        end
        if (count_clear)  ncnt = 0;
        else if (fillhit) ncnt = (mcnt + 1 > 65535) ? 65535 : mcnt + 1;
      end
      @(posedge clk);
      if (rst) on = 1;
      ph = nph; mv = nmv; mdat = ndat; msrc = nsrc; mlast = nlast;
      mwait = nwait; mpulse = npulse; mcnt = ncnt;
    end
  endtask

  initial begin
    logic [FW-1:0] got_f[4];
    logic [FW-1:0] exp_f[4];
    int nf, pulses, dens;

    rst = 1'b1; enable = 1'b0; count_clear = 1'b0; m_ready = 1'b0;
    s0_valid = 1'b0; s1_valid = 1'b0; s0_data = '0; s1_data = '0;
    fork model_loop(); join_none

    repeat (3) tick();
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, 32'h0);
    chk("rst_src_id", src_id, 2'd0);
    chk("rst_count", underrun_count, 16'h0);
    chk("rst_ready", {s0_ready, s1_ready}, 2'b00);

    // Single source, master always ready
    rst = 1'b0; enable = 1'b1; m_ready = 1'b1;
    s0_valid = 1'b1; s0_data = 32'hA5A5_5A5A;
    tick();
    chk("single_s0_ready", s0_ready, 1'b1);
    tick();
    chk("single_m_valid", m_valid, 1'b1);
    chk("single_m_data", m_data, 32'hA5A5_5A5A);
    chk("single_src_id", src_id, 2'd0);
    s0_valid = 1'b0;

    // Both sources continuously valid: strict alternation from s0
    s0_valid = 1'b1; s1_valid = 1'b1;
    s0_data = 32'h1111_1111; s1_data = 32'h2222_2222;
    do_reset();
    nf = 0;
    for (int c = 0; c < 20 && nf < 4; c++) begin
      tick();
      if (m_valid) begin got_f[nf] = m_data; nf++; end
    end
    chk("rr_frames_seen", nf, 4);
    exp_f[0] = 32'h1111_1111; exp_f[1] = 32'h2222_2222;
    exp_f[2] = 32'h1111_1111; exp_f[3] = 32'h2222_2222;
    for (int i = 0; i < nf; i++) chk($sformatf("rr_frame%0d", i), got_f[i], exp_f[i]);
    s0_valid = 1'b0; s1_valid = 1'b0;

    // Starvation: fill frame on the 28th arbitration cycle
    do_reset();
    repeat (FT) tick();
    chk("fill_not_early", underrun, 1'b0);
    tick();
    chk("fill_pulse", underrun, 1'b1);
    chk("fill_m_valid", m_valid, 1'b1);
    chk("fill_m_data", m_data, 32'h0);
    chk("fill_src_id", src_id, 2'd2);
    chk("fill_count", underrun_count, 16'd1);
    tick();
    chk("fill_pulse_width", underrun, 1'b0);

    // Source arrives exactly at timeout: it wins, no fill
    do_reset();
    repeat (FT) tick();
    s1_valid = 1'b1; s1_data = 32'hCAFE_F00D;
    tick();
    s1_valid = 1'b0;
    chk("late_m_valid", m_valid, 1'b1);
    chk("late_src_id", src_id, 2'd1);
    chk("late_m_data", m_data, 32'hCAFE_F00D);
    chk("late_no_underrun", underrun, 1'b0);
    chk("late_count", underrun_count, 16'd0);

    // enable dropped while a frame waits on a stalled master
    m_ready = 1'b0; s0_valid = 1'b1; s0_data = 32'h1357_2468;
    do_reset();
    tick(); tick();
    s0_valid = 1'b0; enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_m_valid", m_valid, 1'b1);
      chk("hold_m_data", m_data, 32'h1357_2468);
    end
    m_ready = 1'b1;
    tick();
    chk("hold_released", m_valid, 1'b0);
    s0_valid = 1'b1;
    tick();
    chk("hold_idle_valid", m_valid, 1'b0);
    chk("hold_idle_ready", s0_ready, 1'b0);
    s0_valid = 1'b0;

    // Saturation from a preloaded count of 0xFFFE
    enable = 1'b0; m_ready = 1'b1;
    do_reset();
    force dut.underrun_count_q = 16'hFFFE;
    preload = 1'b1;
    tick();
    preload = 1'b0;
    release dut.underrun_count_q;
    chk("preload_count", underrun_count, 16'hFFFE);
    enable = 1'b1;
    pulses = 0;
    repeat (100) begin
      tick();
      if (underrun) pulses++;
    end
    chk("sat_pulses", pulses, 3);
    chk("sat_count", underrun_count, 16'hFFFF);

    // Clear coinciding with a fill frame
    enable = 1'b0;
    repeat (5) tick();
    enable = 1'b1;
    repeat (FT) tick();
    count_clear = 1'b1;
    tick();
    count_clear = 1'b0;
    chk("clr_fill_pulse", underrun, 1'b1);
    chk("clr_wins", underrun_count, 16'h0);

    // Randomized traffic with varying source density
    do_reset();
    dens = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 400 == 0) begin
        case ($urandom_range(0, 3))
          0: dens = 0;
          1: dens = 10;
          2: dens = 50;
          default: dens = 90;
        endcase
      end
      enable      = ($urandom % 20) != 0;
      m_ready     = ($urandom % 10) < 7;
      count_clear = ($urandom % 100) == 0;
      rst         = ($urandom % 500) == 0;
      s0_valid    = ($urandom % 100) < dens;
      s1_valid    = ($urandom % 100) < dens;
      s0_data     = $urandom;
      s1_data     = $urandom;
      tick();
    end
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/i2s_frame_arbiter.md
I2S_FRAME_ARBITER -- requirements
Module: i2s_frame_arbiter

Interface
REQ-001 The block SHALL have parameter WORD_LENGTH, default 16, giving bits per channel (one frame = 2*WORD_LENGTH bits, left in the upper half).
REQ-002 The block SHALL have parameter FILL_TIMEOUT, default 28, giving ARB-state cycles without a source transfer before a zero frame is inserted; legal range 1 to 2*WORD_LENGTH-2.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  system clock; all state changes on its rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 enable  in  1  high = serve frames and insert fill frames; low = drain and idle.
REQ-007 count_clear  in  1  synchronous clear of underrun_count.
REQ-008 s0_data, s1_data  in  2*WORD_LENGTH  stereo frame from source 0 and source 1.
REQ-009 s0_valid, s1_valid  in  1  per source: frame available.
REQ-010 s0_ready, s1_ready  out  1  per source: frame taken at this edge when valid is also high.
REQ-011 m_data  out  2*WORD_LENGTH  frame to the I2S master.
REQ-012 m_valid  out  1  m_data holds a frame.
REQ-013 m_ready  in  1  I2S master ready; transfer occurs when m_valid and m_ready are both high at a rising edge.
REQ-014 src_id  out  2  source of the current/last frame: 0 = s0, 1 = s1, 2 = fill.
REQ-015 underrun  out  1  one-cycle pulse when a fill frame is loaded.
REQ-016 underrun_count  out  16  saturating count of fill frames.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, ARB (output register empty) and HOLD (output register full).
REQ-018 IDLE: m_valid=0 and both ready outputs low; go to ARB on the cycle after enable is high.
REQ-019 ARB: at most one sX_ready is high, selected combinationally from s0_valid, s1_valid, last_grant and state; no sX_ready is asserted while enable is low.
REQ-020 Arbitration: one valid source wins; if both are valid, the source not equal to last_grant wins (round robin).
REQ-021 A source transfer at edge N SHALL load m_data, set m_valid=1 from cycle N+1, set src_id, update last_grant and enter HOLD.
REQ-022 The wait counter SHALL clear on ARB entry and increment on each ARB cycle without a transfer.
REQ-023 When the wait counter reaches FILL_TIMEOUT with enable high and no source valid, the block SHALL load an all-zero frame, set src_id=2, pulse underrun, increment underrun_count and enter HOLD, with last_grant unchanged.
REQ-024 A source that becomes valid in the same cycle the timeout is reached SHALL win, and no fill frame SHALL be inserted.
REQ-025 ARB with enable low SHALL go to IDLE with no fill frame.
REQ-026 HOLD: m_data and m_valid SHALL stay stable until the m_ready transfer; the next state is ARB if enable is high, else IDLE; m_valid falls the cycle after the transfer.
REQ-027 Deasserting enable SHALL never withdraw a frame already in HOLD.
REQ-028 underrun_count SHALL saturate at 0xFFFF.
REQ-029 When count_clear and a fill frame coincide, count_clear SHALL win and the count becomes 0.
REQ-030 Source-to-m_valid latency SHALL be 1 cycle; the frame pass-through SHALL never be combinational.

Reset
REQ-031 On rst the block SHALL enter IDLE and set: m_valid=0, m_data=0, s0_ready=s1_ready=0, src_id=0, underrun=0, underrun_count=0, wait counter=0, last_grant=1 (s0 wins the first tie).
REQ-032 rst asserted mid-HOLD SHALL discard the held frame, with no m_valid glitch in the following cycle.

Structure
REQ-033 The shared package i2s_pkg SHALL hold the FSM state encodings, the src_id constants SRC_S0/SRC_S1/SRC_FILL and the default WORD_LENGTH.
REQ-034 The two-way round-robin selection SHALL be the single sub-module i2s_rr_arb2 (inputs: two requests, last_grant; outputs: grant vector).

Verification
REQ-035 Single source: s0 frame 0xA5A5_5A5A valid, m_ready tied high -> m_data=0xA5A5_5A5A and m_valid 1 cycle after the s0 handshake; src_id=0.
REQ-036 Both sources always valid (s0=0x1111_1111, s1=0x2222_2222) -> m_data alternates s0, s1, s0, s1 over 4 frames.
REQ-037 No source valid, enable high, FILL_TIMEOUT=28 -> zero frame loaded on the 28th ARB cycle; underrun pulses once; underrun_count=1; src_id=2.
REQ-038 s1 raises valid exactly at the timeout cycle -> s1 frame delivered, no underrun, count unchanged.
REQ-039 enable dropped during HOLD with m_ready low for 10 cycles -> frame held stable, transferred when m_ready rises, then IDLE with m_valid=0.
REQ-040 Count preloaded to 0xFFFE with 3 fill frames -> count stops at 0xFFFF; count_clear coinciding with a fill frame -> count 0.
